// File: rtl/weight_fetch_sched_if.sv
// Memory read-port bundle between weight_fetch_sched (master) and the shared
// memory (slave): burst request/grant plus the returning 64-bit beat stream.
interface weight_fetch_sched_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [LEN_W-1:0]  mem_rd_len;
    logic              mem_rd_gnt;
    logic              mem_rd_valid;
    logic [63:0]       mem_rd_data;

    modport master (
        output mem_rd_req, mem_rd_addr, mem_rd_len,
        input  mem_rd_gnt, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_rd_len,
        output mem_rd_gnt, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/weight_fetch_sched.sv
// Round-robin burst scheduler feeding two ping-pong weight buffers from one memory read port.
// OP_MODE encoding: 0 = MODE1 (88 beats), 1 = MODE2 (44), 2/3 = MODE3 (22). Optional WFS_ADDR_AUTO_INC_EN.
module weight_fetch_sched #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode_in,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      stop,
    input  logic [1:0]                buf_req,
    weight_fetch_sched_if.master      mem,
    output logic [1:0]                wb_data_valid,
    output logic [63:0]               wb_data,
    output logic                      load_done,
    output logic                      done_buf,
    output logic                      busy,
    output logic                      protocol_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARB    = 2'd1;
    localparam logic [1:0] ST_REQ    = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam logic [LEN_W-1:0] LEN_MODE1 = LEN_W'(88);
    localparam logic [LEN_W-1:0] LEN_MODE2 = LEN_W'(44);
    localparam logic [LEN_W-1:0] LEN_MODE3 = LEN_W'(22);

    logic [1:0]        state_q,    state_d;
    logic [LEN_W-1:0]  mode_len_q, mode_len_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;
    logic              prio_q,     prio_d;
    logic              sel_q,      sel_d;
    logic              stop_q,     stop_d;
    logic [LEN_W-1:0]  cnt_q,      cnt_d;
    logic              req_q,      req_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [1:0]        wbv_q,      wbv_d;
    logic [63:0]       wbd_q,      wbd_d;
    logic              done_q,     done_d;
    logic              done_buf_q, done_buf_d;

    logic [LEN_W-1:0]  start_len;
    logic              last_beat;

    always_comb begin
        case (mode_in)
            2'd0:    start_len = LEN_MODE1;
            2'd1:    start_len = LEN_MODE2;
            default: start_len = LEN_MODE3;
        endcase
    end

    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        mode_len_d = mode_len_q;
        cur_addr_d = cur_addr_q;
        busy_d     = busy_q;
        err_d      = err_q;
        prio_d     = prio_q;
        sel_d      = sel_q;
        stop_d     = stop_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wbv_d      = '0;
        wbd_d      = wbd_q;
        done_d     = 1'b0;
        done_buf_d = done_buf_q;

        // Beats are only legal while streaming; anything else is dropped and flagged.
        if (mem.mem_rd_valid && (state_q != ST_STREAM))
            err_d = 1'b1;
        if (stop && (state_q != ST_IDLE))
            stop_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ARB;
                    mode_len_d = start_len;
                    cur_addr_d = base_addr;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    prio_d     = 1'b0;
                    stop_d     = 1'b0;
                end
            end

            ST_ARB: begin
                if (stop_q || stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    stop_d  = 1'b0;
                end else if (|buf_req) begin
                    sel_d   = buf_req[prio_q] ? prio_q : ~prio_q;
                    prio_d  = ~sel_d;
                    req_d   = 1'b1;
                    addr_d  = cur_addr_q;
                    len_d   = mode_len_q;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (mem.mem_rd_gnt) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end
            end

            default: begin
                if (mem.mem_rd_valid) begin
                    wbd_d        = mem.mem_rd_data;
                    wbv_d[sel_q] = 1'b1;
                    if (cnt_q != '1)
                        cnt_d = cnt_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d    = ST_ARB;
                        done_d     = 1'b1;
                        done_buf_d = sel_q;
`ifdef WFS_ADDR_AUTO_INC_EN
                        cur_addr_d = cur_addr_q + ADDR_W'({len_q, 3'b000});
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_len_q <= '0;
            cur_addr_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            stop_q     <= 1'b0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wbv_q      <= '0;
            wbd_q      <= '0;
            done_q     <= 1'b0;
            done_buf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_len_q <= mode_len_d;
            cur_addr_q <= cur_addr_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            stop_q     <= stop_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wbv_q      <= wbv_d;
            wbd_q      <= wbd_d;
            done_q     <= done_d;
            done_buf_q <= done_buf_d;
        end
    end

    assign mem.mem_rd_req  = req_q;
    assign mem.mem_rd_addr = addr_q;
    assign mem.mem_rd_len  = len_q;
    assign wb_data_valid   = wbv_q;
    assign wb_data         = wbd_q;
    assign load_done       = done_q;
    assign done_buf        = done_buf_q;
    assign busy            = busy_q;
    assign protocol_err    = err_q;

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Directed bench for weight_fetch_sched: bursts, round-robin, stop, protocol errors, reset, ignored start.
// Expected addresses follow WFS_ADDR_AUTO_INC_EN when it is defined for the build.
module tb_weight_fetch_sched;

`ifdef WFS_ADDR_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [31:0] base_addr = '0;
    logic        stop = 1'b0;
    logic [1:0]  buf_req = '0;
    logic [1:0]  wb_data_valid;
    logic [63:0] wb_data;
    logic        load_done;
    logic        done_buf;
    logic        busy;
    logic        protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    weight_fetch_sched_if #(.ADDR_W(32), .LEN_W(8)) mem_if ();

    weight_fetch_sched #(.ADDR_W(32), .LEN_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode_in      (mode_in),
        .base_addr    (base_addr),
        .stop         (stop),
        .buf_req      (buf_req),
        .mem          (mem_if.master),
        .wb_data_valid(wb_data_valid),
        .wb_data      (wb_data),
        .load_done    (load_done),
        .done_buf     (done_buf),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req"},  64'(mem_if.mem_rd_req), 64'd0);
        chk({tag, ".addr"}, 64'(mem_if.mem_rd_addr), 64'd0);
        chk({tag, ".len"},  64'(mem_if.mem_rd_len), 64'd0);
        chk({tag, ".wbv"},  64'(wb_data_valid), 64'd0);
        chk({tag, ".wbd"},  wb_data, 64'd0);
        chk({tag, ".done"}, 64'(load_done), 64'd0);
        chk({tag, ".dbuf"}, 64'(done_buf), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".err"},  64'(protocol_err), 64'd0);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [31:0] a);
        mode_in   = m;
        base_addr = a;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Serves one burst: checks the request, grants after 2 cycles, streams len beats.
    task automatic serve_burst(input string tag, input logic [31:0] exp_addr, input int exp_len,
                               input int exp_buf, input int stop_at, input int start_at,
                               input int rst_at);
        int waited = 0;
        int pulses = 0;
        int wrong  = 0;
        int bad    = 0;
        logic [63:0] d;
        while (!mem_if.mem_rd_req && waited < 20) begin
            tick();
            waited++;
        end
        if (!mem_if.mem_rd_req) begin
            chk({tag, ".req_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({tag, ".addr"}, 64'(mem_if.mem_rd_addr), 64'(exp_addr));
        chk({tag, ".len"},  64'(mem_if.mem_rd_len), 64'(exp_len));
        tick();
        tick();
        chk({tag, ".req_held"}, 64'(mem_if.mem_rd_req), 64'd1);
        mem_if.mem_rd_gnt = 1'b1;
        tick();
        mem_if.mem_rd_gnt = 1'b0;
        chk({tag, ".req_drop"}, 64'(mem_if.mem_rd_req), 64'd0);
        for (int i = 0; i < exp_len; i++) begin
            if (i == rst_at) begin
                mem_if.mem_rd_valid = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_reset_outputs({tag, ".rst"});
                return;
            end
            d = {exp_addr ^ 32'hA5A5_0000, 32'(i) * 32'h0101_0101};
            mem_if.mem_rd_valid = 1'b1;
            mem_if.mem_rd_data  = d;
            if (i == stop_at) stop = 1'b1;
            if (i == start_at) begin
                start     = 1'b1;
                mode_in   = 2'd0;
                base_addr = 32'hDEAD_0000;
            end
            tick();
            stop  = 1'b0;
            start = 1'b0;
            if (wb_data_valid[exp_buf[0]]) pulses++;
            if (wb_data_valid[~exp_buf[0]]) wrong++;
            if (wb_data !== d) bad++;
        end
        mem_if.mem_rd_valid = 1'b0;
        chk({tag, ".pulses"}, 64'(pulses), 64'(exp_len));
        chk({tag, ".wrong_buf"}, 64'(wrong), 64'd0);
        chk({tag, ".data_bad"}, 64'(bad), 64'd0);
        chk({tag, ".load_done"}, 64'(load_done), 64'd1);
        chk({tag, ".done_buf"}, 64'(done_buf), 64'(exp_buf));
    endtask

    task automatic idle_check(input string tag);
        int reqs = 0;
        tick();
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done_clr"}, 64'(load_done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_if.mem_rd_req) reqs++;
        end
        chk({tag, ".no_req"}, 64'(reqs), 64'd0);
    endtask

    initial begin
        mem_if.mem_rd_gnt   = 1'b0;
        mem_if.mem_rd_valid = 1'b0;
        mem_if.mem_rd_data  = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // MODE1 single buffer, with start-to-request timing
        buf_req = 2'b01;
        do_start(2'd0, 32'h1000);
        chk("m1.busy", 64'(busy), 64'd1);
        chk("m1.req_early", 64'(mem_if.mem_rd_req), 64'd0);
        tick();
        chk("m1.req_t2", 64'(mem_if.mem_rd_req), 64'd1);
        serve_burst("m1", 32'h1000, 88, 0, 50, -1, -1);
        idle_check("m1_idle");

        // MODE3 both buffers: alternating grants
        buf_req = 2'b11;
        do_start(2'd2, 32'h1000);
        serve_burst("rr0", 32'h1000, 22, 0, -1, -1, -1);
        serve_burst("rr1", AUTO_INC ? 32'h10B0 : 32'h1000, 22, 1, -1, -1, -1);
        serve_burst("rr2", AUTO_INC ? 32'h1160 : 32'h1000, 22, 0, 5, -1, -1);
        idle_check("rr_idle");

        // MODE2 stop at beat 10 never truncates the burst
        buf_req = 2'b11;
        do_start(2'd1, 32'h2000);
        serve_burst("stop", 32'h2000, 44, 0, 10, -1, -1);
        idle_check("stop_idle");

        // Stray beat while arbitrating
        buf_req = 2'b00;
        do_start(2'd0, 32'h2000);
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 64'hFFFF_0000_FFFF_0000;
        tick();
        mem_if.mem_rd_valid = 1'b0;
        chk("err.wbv", 64'(wb_data_valid), 64'd0);
        chk("err.set", 64'(protocol_err), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("err.idle_busy", 64'(busy), 64'd0);
        chk("err.sticky", 64'(protocol_err), 64'd1);
        do_start(2'd0, 32'h2000);
        chk("err.cleared", 64'(protocol_err), 64'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Reset mid-burst, then a normal MODE3 burst
        buf_req = 2'b01;
        do_start(2'd0, 32'h3000);
        serve_burst("rst", 32'h3000, 88, 0, -1, -1, 30);
        do_start(2'd2, 32'h3000);
        serve_burst("post_rst", 32'h3000, 22, 0, 3, -1, -1);
        idle_check("post_rst_idle");

        // Start during STREAM is ignored
        buf_req = 2'b11;
        do_start(2'd1, 32'h4000);
        serve_burst("ign0", 32'h4000, 44, 0, -1, 5, -1);
        serve_burst("ign1", AUTO_INC ? 32'h4160 : 32'h4000, 44, 1, 2, -1, -1);
        idle_check("ign_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/weight_fetch_sched.md
# weight_fetch_sched

Sequences and arbitrates weight loads from the shared memory read port into two ping-pong `weight_buffer` instances. It round-robins between the buffers' `mem_req` lines, issues one burst read per grant sized by the operating mode, and steers returning 64-bit beats to the selected buffer. It also reports load completion and protocol errors to the layer controller.

## Interface
- `ADDR_W`, 32, byte-address width of the memory read port
- `LEN_W`, 8, width of the burst-length field (beats)
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse: latch `mode_in`/`base_addr`, enable scheduling
- `mode_in`  in  OP_MODE  operating mode, sampled only on accepted `start`
- `base_addr`  in  ADDR_W  first weight byte address, 8-byte aligned
- `stop`  in  1  one-cycle pulse: stop granting after current burst
- `buf_req`  in  2  `mem_req` from weight buffer 0/1
- `mem_rd_req`  out  1  burst read request, held until `mem_rd_gnt`
- `mem_rd_addr`  out  ADDR_W  burst start address, stable while `mem_rd_req`
- `mem_rd_len`  out  LEN_W  burst length in beats, stable while `mem_rd_req`
- `mem_rd_gnt`  in  1  memory accepts the request this cycle
- `mem_rd_valid`  in  1  returning data beat
- `mem_rd_data`  in  64  returning data
- `wb_data_valid`  out  2  per-buffer `mem_data_valid`, one-hot or zero
- `wb_data`  out  64  `weight_data` to both buffers
- `load_done`  out  1  one-cycle pulse after last beat of a burst is forwarded
- `done_buf`  out  1  buffer index that `load_done` refers to
- `busy`  out  1  enabled (started, not yet stopped and idle)
- `protocol_err`  out  1  sticky; cleared only by `rst` or accepted `start`

## Operation
- Beats per burst from the latched mode: MODE1 = 88, MODE2 = 44, MODE3 = 22. `mem_rd_len` = that count.
- FSM states: IDLE, ARB, REQ, STREAM.
- IDLE: `start` moves the FSM to ARB. The same cycle latches mode, sets `cur_addr` = `base_addr` and `busy` = 1, clears `protocol_err`, and resets priority to buffer 0. `start` in any other state is ignored.
- ARB: if `stop` has been seen, go to IDLE with `busy` = 0. Otherwise, if any `buf_req` bit is set, grant round-robin (priority pointer first; pointer flips to the other buffer after each granted burst), latch `sel`, and go to REQ. If no bit is set, stay in ARB.
- REQ: assert `mem_rd_req` with `cur_addr` and len. On `mem_rd_gnt`, go to STREAM and clear the beat counter.
- STREAM:
  - Each `mem_rd_valid` forwards the beat: `wb_data` <= `mem_rd_data` and `wb_data_valid[sel]` <= 1.
  - Beat counter increments on each beat.
  - On the last beat, go to ARB. The next cycle pulses `load_done` with `done_buf` = `sel`.
- `buf_req` is sampled only in ARB. Deasserting it mid-burst does not abort the burst.
- `stop` is latched in any non-IDLE state and takes effect at the next ARB. It never truncates a burst.
- `mem_rd_valid` in IDLE, ARB or REQ is dropped and sets `protocol_err`.
- `mem_rd_gnt` outside REQ is ignored.
- Beat counter is LEN_W bits and does not wrap; the maximum count is 88.

## Timing
- Reset values: `mem_rd_req` 0, `mem_rd_addr` 0, `mem_rd_len` 0, `wb_data_valid` 0, `wb_data` 0, `load_done` 0, `done_buf` 0, `busy` 0, `protocol_err` 0. FSM goes to IDLE and the priority pointer to 0.
- `rst` mid-burst returns the FSM to IDLE immediately. Remaining beats from memory are then dropped and flagged as errors.
- Timing relative to `start` in cycle t: ARB at t+1, earliest `mem_rd_req` at t+2.
- Beat forwarding latency: `mem_rd_valid` at t gives `wb_data_valid`/`wb_data` at t+1 (registered).
- Last beat at t: `wb_data_valid` at t+1, `load_done` at t+1, FSM in ARB at t+1, next `mem_rd_req` earliest at t+2.
- Back-to-back beats forward at a rate of one per cycle. Gaps in `mem_rd_valid` pass through unchanged.

## Configuration
- `WFS_ADDR_AUTO_INC_EN` defined: after each burst, `cur_addr` += len×8. A 32-bit address wraps modulo 2^ADDR_W.
- `WFS_ADDR_AUTO_INC_EN` undefined: every burst uses the latched `base_addr`, so both buffers reload the same weight tile.

## Test plan
- MODE1, `base_addr` = 0x1000, `buf_req` = 2'b01, grant after 2 cycles, 88 consecutive beats. Required:
  - `mem_rd_len` = 88, `mem_rd_addr` = 0x1000.
  - 88 pulses on `wb_data_valid[0]`, data matching beats one cycle later.
  - `load_done` with `done_buf` = 0 on the cycle after the last beat.
- Both `buf_req` bits held high, MODE3: bursts alternate buf0, buf1, buf0, each with `mem_rd_len` = 22. With `WFS_ADDR_AUTO_INC_EN`, addresses are 0x1000, 0x10B0, 0x1160.
- `stop` pulsed at beat 10 of a MODE2 burst: all 44 beats are forwarded, then `load_done`, then IDLE with `busy` = 0 and no further `mem_rd_req`.
- `mem_rd_valid` pulsed while in ARB: `wb_data_valid` stays 0 and `protocol_err` = 1 until the next accepted `start`.
- `rst` asserted at beat 30 of 88: on the next cycle all outputs equal reset values. A subsequent `start` produces a normal burst.
- `start` pulsed during STREAM with a different `mode_in`: ignored, and the current and next bursts keep the original length.
